// File: rtl/seq_controller_if.sv
// Memory bus between the sequencing controller (master) and instruction/data memory (slave).
interface seq_controller_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle Moore sequencer: fetch/decode/execute/memory/write-back for a 16-bit
// single-bus datapath, with HALT left only through the asynchronous reset.
module seq_controller #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic              clock,
    input  logic              reset,
    seq_controller_if.master  bus,
    input  logic [15:0]       rs_data,
    input  logic              alu_zero,
    output logic [15:0]       ir,
    output logic [15:0]       pc,
    output logic [2:0]        s_alu,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic              rf_src_mem,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  opcode;
    logic        is_halt, is_alu, is_load, is_store, is_brz, is_jmp;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o, mem_wr_o;

    assign opcode = ir_q[15:12];

    // HALT_OP takes priority so a remapped halt opcode overrides its default class
    always_comb begin
        is_halt  = (opcode == HALT_OP);
        is_alu   = !is_halt && !opcode[3];
        is_load  = !is_halt && (opcode == 4'h8);
        is_store = !is_halt && (opcode == 4'h9);
        is_brz   = !is_halt && (opcode == 4'hA);
        is_jmp   = !is_halt && (opcode == 4'hB);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mem_addr_o = pc_q;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        s_alu      = 3'b000;
        rf_we      = 1'b0;
        rf_src_mem = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_o = 1'b1;
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    state_d = S_EXEC;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                    if (is_brz && alu_zero) pc_d = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
                    if (is_jmp)             pc_d = {4'h0, ir_q[11:0]};
                end
            end
            S_EXEC: begin
                s_alu   = opcode[2:0];
                state_d = S_WB;
            end
            S_MEM: begin
                mem_addr_o = rs_data;
                mem_rd_o   = is_load;
                mem_wr_o   = is_store;
                if (bus.mem_ready) state_d = is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_src_mem = is_load;
                if (is_alu) s_alu = opcode[2:0];
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.mem_addr = mem_addr_o;
    assign bus.mem_rd   = mem_rd_o;
    assign bus.mem_wr   = mem_wr_o;
    assign rf_waddr     = ir_q[11:9];
    assign ir           = ir_q;
    assign pc           = pc_q;

endmodule
